fir_rf_loader: RTL
==================

FIR_RF_LOADER -- requirements
Module: fir_rf_loader

Interface
REQ-001 Parameter NUM_TAPS, default 4, number of filter taps held in the register file (legal range 1..8).
REQ-002 Parameter COEF_BASE, default 5'd8, register-file address of coefficient 0.
REQ-003 Parameter SAMPLE_BASE, default 5'd16, register-file address of the newest sample.
REQ-004 Parameter TIMEOUT, default 1024, maximum RUN cycles allowed per frame.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 coef_we  input  1  coefficient write request.
REQ-008 coef_idx  input  3  coefficient index.
REQ-009 coef_data  input  32  coefficient value.
REQ-010 in_valid  input  1  sample offered.
REQ-011 in_data  input  32  sample value.
REQ-012 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-013 fir_rf_we / fir_rf_waddr / fir_rf_wdata  output  1/5/32  register-file write port into the processor core.
REQ-014 core_hold  output  1  high holds the processor core in reset.
REQ-015 fir_start  output  1  one-cycle start pulse to the core.
REQ-016 fir_done  input  1  core completion flag.
REQ-017 frame_done  output  1  one-cycle pulse at end of each frame.
REQ-018 timeout_err  output  1  sticky error flag.
REQ-019 frame_count  output  16  number of completed frames.

Function
REQ-020 The block SHALL implement states IDLE, WRITE, START, RUN, DONE.
REQ-021 The block SHALL keep a shadow window win[0..NUM_TAPS-1]; on sample accept win[0]<=in_data and win[k]<=win[k-1], with the oldest sample discarded.
REQ-022 in_ready SHALL be 1 only in IDLE with coef_we=0.
REQ-023 In IDLE, coef_we with coef_idx<NUM_TAPS SHALL drive fir_rf_we=1, fir_rf_waddr=COEF_BASE+coef_idx, fir_rf_wdata=coef_data combinationally in the same cycle; coef_idx>=NUM_TAPS SHALL be ignored.
REQ-024 coef_we outside IDLE SHALL be ignored; when coef_we and in_valid are both high in IDLE, the coefficient write wins and no sample is accepted.
REQ-025 A sample accept in IDLE at cycle T SHALL move to WRITE; in WRITE cycle i (T+1+i, i=0..NUM_TAPS-1) the block SHALL drive fir_rf_we=1, waddr=SAMPLE_BASE+i, wdata=win[i] (post-shift values).
REQ-026 After the last WRITE cycle the block SHALL enter START for exactly one cycle with fir_start=1 and core_hold=0.
REQ-027 core_hold SHALL be 0 in START and RUN and 1 in all other states.
REQ-028 In RUN, a 16-bit cycle counter cleared in START SHALL increment each cycle; fir_done=1 SHALL move to DONE.
REQ-029 If the counter reaches TIMEOUT-1 in RUN without fir_done, timeout_err SHALL set (sticky) and the block SHALL move to DONE.
REQ-030 fir_done and timeout on the same cycle: fir_done wins and timeout_err SHALL NOT set.
REQ-031 fir_done outside RUN SHALL be ignored.
REQ-032 DONE SHALL last one cycle with frame_done=1 and frame_count incremented (0xFFFF wraps to 0), then return to IDLE.
REQ-033 fir_rf_we SHALL be 0 in START, RUN and DONE.

Reset
REQ-034 With reset=0 at a rising edge the block SHALL enter IDLE; win, cycle counter, frame_count and timeout_err SHALL clear to 0; core_hold=1; fir_start, frame_done, fir_rf_we=0; fir_rf_waddr, fir_rf_wdata=0.
REQ-035 in_ready SHALL be 0 while reset=0.
REQ-036 Reset in any state SHALL abort the frame with no frame_done pulse and no frame_count increment.
REQ-037 timeout_err SHALL clear only on reset.

Verification
REQ-038 Coefficients: in IDLE, coef_we with idx 0..3 and data 1..4 -> writes to addresses 8..11 with data 1..4; idx 5 -> no write.
REQ-039 Sample frame: accept 0x10 -> writes (16,0x10),(17,0),(18,0),(19,0) on T+1..T+4, fir_start at T+5; fir_done 3 cycles later -> frame_done, frame_count=1, core_hold=1.
REQ-040 Window shift: samples 0x10,0x20,0x30 in successive frames -> third frame writes (16,0x30),(17,0x20),(18,0x10),(19,0).
REQ-041 Timeout: TIMEOUT=8, fir_done held 0 -> DONE after 8 RUN cycles, timeout_err=1, persisting across later frames.
REQ-042 Conflict and abort: coef_we and in_valid together in IDLE -> coefficient written, in_ready=0; reset asserted mid-WRITE -> IDLE, fir_rf_we=0, frame_count unchanged.

Source files
------------

// File: rtl/fir_rf_loader_if.sv
// Bus bundle between the FIR loader and its environment:
// coefficient/sample inputs, register-file write port and core control.
interface fir_rf_loader_if;
   logic        coef_we;
   logic [2:0]  coef_idx;
   logic [31:0] coef_data;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        fir_rf_we;
   logic [4:0]  fir_rf_waddr;
   logic [31:0] fir_rf_wdata;
   logic        core_hold;
   logic        fir_start;
   logic        fir_done;
   logic        frame_done;
   logic        timeout_err;
   logic [15:0] frame_count;

   modport master (
      output coef_we, coef_idx, coef_data,
      output in_valid, in_data, fir_done,
      input  in_ready, fir_rf_we, fir_rf_waddr, fir_rf_wdata,
      input  core_hold, fir_start, frame_done,
      input  timeout_err, frame_count
   );

   modport slave (
      input  coef_we, coef_idx, coef_data,
      input  in_valid, in_data, fir_done,
      output in_ready, fir_rf_we, fir_rf_waddr, fir_rf_wdata,
      output core_hold, fir_start, frame_done,
      output timeout_err, frame_count
   );
endinterface

// File: rtl/fir_rf_loader.sv
// Loads a sample window into the core register file, starts the core,
// waits for completion or timeout, and counts finished frames.
module fir_rf_loader #(
   parameter int         NUM_TAPS    = 4,
   parameter logic [4:0] COEF_BASE   = 5'd8,
   parameter logic [4:0] SAMPLE_BASE = 5'd16,
   parameter int         TIMEOUT     = 1024
) (
   input logic            clock,
   input logic            reset,
   fir_rf_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_START, S_RUN, S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_idx;
   logic [15:0] r_cnt;
   logic [15:0] r_frame_count;
   logic        r_timeout_err;
   logic [31:0] r_win [NUM_TAPS];

   logic        w_idle;
   logic        w_accept;
   logic        w_coef_wr;
   logic        w_tmo;
   logic        w_last_wr;
   logic [31:0] w_win_sel;

   assign w_idle    = reset && (r_state == S_IDLE);
   assign w_coef_wr = w_idle && bus.coef_we &&
                      ({1'b0, bus.coef_idx} < 4'(NUM_TAPS));
   assign w_accept  = w_idle && !bus.coef_we && bus.in_valid;
   assign w_last_wr = (r_idx == 3'(NUM_TAPS - 1));
   // fir_done in the final cycle takes precedence over the timeout
   assign w_tmo     = (r_state == S_RUN) && !bus.fir_done &&
                      (r_cnt == 16'(TIMEOUT - 1));

   always_comb begin
      w_win_sel = '0;
      for (int k = 0; k < NUM_TAPS; k++)
         if (r_idx == 3'(k)) w_win_sel = r_win[k];
   end

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_WRITE;
         S_WRITE: if (w_last_wr) w_next = S_START;
         S_START: w_next = S_RUN;
         S_RUN:   if (bus.fir_done || w_tmo) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_idx         <= '0;
         r_cnt         <= '0;
         r_frame_count <= '0;
         r_timeout_err <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) r_win[k] <= '0;
      end else begin
         if (w_accept) begin
            r_win[0] <= bus.in_data;
            for (int k = 1; k < NUM_TAPS; k++) r_win[k] <= r_win[k-1];
         end
         r_idx <= (r_state == S_WRITE) ? r_idx + 3'd1 : 3'd0;
         case (r_state)
            S_START: r_cnt <= '0;
            S_RUN: begin
               r_cnt <= r_cnt + 16'd1;
               if (w_tmo) r_timeout_err <= 1'b1;
            end
            S_DONE:  r_frame_count <= r_frame_count + 16'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.in_ready     = w_idle && !bus.coef_we;
      bus.fir_rf_we    = 1'b0;
      bus.fir_rf_waddr = '0;
      bus.fir_rf_wdata = '0;
      bus.core_hold    = 1'b1;
      bus.fir_start    = 1'b0;
      bus.frame_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_coef_wr) begin
               bus.fir_rf_we    = 1'b1;
               bus.fir_rf_waddr = COEF_BASE + {2'b00, bus.coef_idx};
               bus.fir_rf_wdata = bus.coef_data;
            end
         end
         S_WRITE: begin
            if (reset) begin
               bus.fir_rf_we    = 1'b1;
               bus.fir_rf_waddr = SAMPLE_BASE + {2'b00, r_idx};
               bus.fir_rf_wdata = w_win_sel;
            end
         end
         S_START: begin
            bus.core_hold = 1'b0;
            bus.fir_start = 1'b1;
         end
         S_RUN:   bus.core_hold  = 1'b0;
         S_DONE:  bus.frame_done = 1'b1;
         default: ;
      endcase
   end

   assign bus.timeout_err = r_timeout_err;
   assign bus.frame_count = r_frame_count;

endmodule
